// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrowIn, one bit per clock.
// Start/done handshake; result and borrow-out held until next completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iStart,
   input  logic             iB,
   input  logic [WIDTH-1:0] iData_a,
   input  logic [WIDTH-1:0] iData_b,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oData,
   output logic             oBorrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t stateNext;

   logic [WIDTH-1:0] shA;
   logic [WIDTH-1:0] shB;
   logic [WIDTH-1:0] shR;
   logic             br;
   logic [CW-1:0]    cnt;

   logic d;
   logic brNext;
   logic load;
   logic last;

   always_comb begin
      d      = shA[0] ^ shB[0] ^ br;
      brNext = (~shA[0] & shB[0]) | (~(shA[0] ^ shB[0]) & br);
      last   = (cnt == LAST);
   end

   always_comb begin
      stateNext = state;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (iStart) begin
               stateNext = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (last) stateNext = DONE;
         end
         DONE: begin
            if (iStart) begin
               stateNext = RUN;
               load      = 1'b1;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= IDLE;
      else         state <= stateNext;
   end

   // Outputs move only on the completion edge; during RUN they hold.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         shA     <= '0;
         shB     <= '0;
         shR     <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         oData   <= '0;
         oBorrow <= 1'b0;
      end else if (load) begin
         shA <= iData_a;
         shB <= iData_b;
         shR <= '0;
         br  <= iB;
         cnt <= '0;
      end else if (state == RUN) begin
         shA <= shA >> 1;
         shB <= shB >> 1;
         shR <= {d, shR[WIDTH-1:1]};
         br  <= brNext;
         cnt <= cnt + 1'b1;
         if (last) begin
            oData   <= {d, shR[WIDTH-1:1]};
            oBorrow <= brNext;
         end
      end
   end

   assign oBusy = (state == RUN);
   assign oDone = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table,
// multi-cycle corner sequences and a random sweep.
module tb_serial_subtractor;

   logic       iClk = 1'b0;
   logic       iRst_n = 1'b1;
   logic       iStart = 1'b0;
   logic       iB = 1'b0;
   logic [7:0] iData_a = '0;
   logic [7:0] iData_b = '0;
   logic       oBusy;
   logic       oDone;
   logic [7:0] oData;
   logic       oBorrow;

   serial_subtractor #(.WIDTH(8)) dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iStart  (iStart),
      .iB      (iB),
      .iData_a (iData_a),
      .iData_b (iData_b),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oData   (oData),
      .oBorrow (oBorrow)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic       b;
      logic [7:0] a;
      logic [7:0] s;
      logic [7:0] expD;
      logic       expBr;
   } vec_t;

   vec_t vecs[6];

   int checks = 0;
   int errors = 0;
   logic [7:0] lastData = '0;
   logic       lastBorrow = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called just after a clock edge; returns just after the done edge.
   task automatic runOp(input string nm, input logic b, input logic [7:0] a,
                        input logic [7:0] s, input logic [7:0] expD,
                        input logic expBr);
      int  lat;
      bit  seen;
      bit  stable;
      iB = b;
      iData_a = a;
      iData_b = s;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      chk($sformatf("%s busy", nm), 32'(oBusy), 32'd1);
      lat = 0;
      seen = 0;
      stable = 1;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(posedge iClk); #1;
         if (oBusy && oDone) stable = 0;
         if (oDone) begin
            seen = 1;
            lat = k;
         end else if (oData !== lastData || oBorrow !== lastBorrow) begin
            stable = 0;
         end
      end
      chk($sformatf("%s latency", nm), 32'(lat), 32'd8);
      chk($sformatf("%s stable", nm), 32'(stable), 32'd1);
      chk($sformatf("%s data", nm), 32'(oData), 32'(expD));
      chk($sformatf("%s borrow", nm), 32'(oBorrow), 32'(expBr));
      lastData = expD;
      lastBorrow = expBr;
   endtask

   initial begin
      int busyCnt;
      int doneCnt;
      int doneAt;
      int d1;
      int d2;
      logic [7:0] r1;
      logic [7:0] r2;
      logic       b1;
      logic       b2;
      logic [8:0] full;

      vecs[0] = '{1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 8'h89, 8'h8D, 8'hFC, 1'b1};
      vecs[3] = '{1'b0, 8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b1};
      vecs[5] = '{1'b1, 8'h81, 8'h03, 8'h7D, 1'b0};

      #2 iRst_n = 1'b0;
      #1;
      chk("rst busy", 32'(oBusy), 32'd0);
      chk("rst done", 32'(oDone), 32'd0);
      chk("rst data", 32'(oData), 32'd0);
      chk("rst borrow", 32'(oBorrow), 32'd0);
      @(posedge iClk);
      @(posedge iClk); #1;
      iRst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         runOp($sformatf("vec%0d", i), vecs[i].b, vecs[i].a, vecs[i].s,
               vecs[i].expD, vecs[i].expBr);

      // Busy lockout: second start mid-run must be ignored.
      @(posedge iClk); #1;
      iB = 1'b0;
      iData_a = 8'h10;
      iData_b = 8'h01;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      busyCnt = oBusy ? 1 : 0;
      doneCnt = 0;
      doneAt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge iClk); #1;
         if (k == 2) begin
            iStart = 1'b1;
            iData_a = 8'hAA;
            iData_b = 8'h55;
         end
         if (k == 3) iStart = 1'b0;
         if (oBusy) busyCnt++;
         if (oDone) begin
            doneCnt++;
            doneAt = k;
            r1 = oData;
            b1 = oBorrow;
         end
      end
      chk("lock doneCnt", 32'(doneCnt), 32'd1);
      chk("lock doneAt", 32'(doneAt), 32'd8);
      chk("lock busyCnt", 32'(busyCnt), 32'd8);
      chk("lock data", 32'(r1), 32'h0F);
      chk("lock borrow", 32'(b1), 32'd0);

      // Back-to-back with iStart held high.
      iB = 1'b1;
      iData_a = 8'h83;
      iData_b = 8'h81;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iData_a = 8'h03;
      d1 = 0;
      d2 = 0;
      r1 = '0; r2 = '0; b1 = 1'b0; b2 = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge iClk); #1;
         if (k == 9) iStart = 1'b0;
         if (oDone) begin
            if (d1 == 0) begin
               d1 = k; r1 = oData; b1 = oBorrow;
            end else begin
               d2 = k; r2 = oData; b2 = oBorrow;
            end
         end
      end
      chk("b2b first at", 32'(d1), 32'd8);
      chk("b2b gap", 32'(d2 - d1), 32'd9);
      chk("b2b data1", 32'(r1), 32'h01);
      chk("b2b borrow1", 32'(b1), 32'd0);
      chk("b2b data2", 32'(r2), 32'h81);
      chk("b2b borrow2", 32'(b2), 32'd1);
      lastData = 8'h81;
      lastBorrow = 1'b1;

      // Reset mid-run discards the operation.
      iB = 1'b0;
      iData_a = 8'h50;
      iData_b = 8'h20;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge iClk); #1;
      end
      iRst_n = 1'b0;
      #1;
      chk("mid rst busy", 32'(oBusy), 32'd0);
      chk("mid rst done", 32'(oDone), 32'd0);
      chk("mid rst data", 32'(oData), 32'd0);
      chk("mid rst borrow", 32'(oBorrow), 32'd0);
      @(posedge iClk); #1;
      iRst_n = 1'b1;
      doneCnt = 0;
      busyCnt = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge iClk); #1;
         if (oDone) doneCnt++;
         if (oBusy) busyCnt++;
      end
      chk("post rst done", 32'(doneCnt), 32'd0);
      chk("post rst busy", 32'(busyCnt), 32'd0);
      lastData = '0;
      lastBorrow = 1'b0;
      runOp("fresh", 1'b0, 8'h50, 8'h20, 8'h30, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         logic [7:0] a;
         logic [7:0] s;
         logic       b;
         a = 8'($urandom);
         s = 8'($urandom);
         b = 1'($urandom);
         full = {1'b0, a} - {1'b0, s} - {8'd0, b};
         runOp($sformatf("rnd%0d", i), b, a, s, full[7:0], full[8]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with borrow-in, computing iData_a − iData_b − iB one bit per clock under a start/done handshake. It is the inverse companion to the team's combinational 8-bit adder (iC, iData_a, iData_b → oData/oData_C). It serves area-constrained datapaths where a multi-cycle result is acceptable, and it is cross-checked against that adder: a + (~b) + ~iB equals the difference.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- iClk  input  1  rising-edge clock
- iRst_n  input  1  asynchronous, active-low reset
- iStart  input  1  request a subtraction; sampled on rising edge; honoured only in IDLE or DONE
- iB  input  1  borrow-in, captured with iStart
- iData_a  input  WIDTH  minuend, captured with iStart
- iData_b  input  WIDTH  subtrahend, captured with iStart
- oBusy  output  1  high while in RUN
- oDone  output  1  one-cycle pulse: oData/oBorrow just updated
- oData  output  WIDTH  difference (a − b − iB) mod 2^WIDTH, held until next completion
- oBorrow  output  1  borrow-out: 1 iff a < b + iB (unsigned), held with oData

## Operation
- States: IDLE, RUN, DONE.
  - Encoding is free.
  - Reset state is IDLE.
- IDLE → RUN on iStart=1:
  - latch iData_a and iData_b into internal shift registers A and B;
  - latch iB into the borrow flop br;
  - clear the bit counter cnt to 0.
- RUN, each clock:
  - d = A[0] ^ B[0] ^ br
  - br ← (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - A and B shift right by one.
  - Internal result register R shifts right with d entering at the MSB.
  - cnt increments.
- RUN → DONE on the edge processing bit WIDTH−1 (cnt = WIDTH−1). On that same edge:
  - oData ← final R (including bit d);
  - oBorrow ← final br;
  - oDone ← 1.
- DONE is one cycle:
  - with iStart=1 → RUN, capturing new operands (back-to-back operation allowed);
  - otherwise → IDLE.
- iStart is ignored while in RUN. Operands and iB are not re-sampled, and the operation in progress continues undisturbed.
- oData and oBorrow change only on the completion edge. During RUN they keep the previous result.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH.
  - Borrow-out is the (WIDTH+1)th bit of the true difference.
  - No overflow flag is produced.
- Reset (iRst_n=0, any time including mid-RUN):
  - immediately forces IDLE;
  - oBusy=0, oDone=0, oData=0, oBorrow=0;
  - A, B, R, br, cnt cleared.
  - The operation in progress is discarded and no oDone follows.

## Timing
- Start accepted at edge T0. oBusy is 1 from T0 through edge T0+WIDTH.
- oDone is high for exactly the cycle following edge T0+WIDTH. Latency is WIDTH clocks (8 by default).
- oBusy and oDone are never high together.
- Back-to-back throughput: iStart held high gives one result every WIDTH+1 clocks.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset deassertion is synchronous to iClk by system convention. The first accepted start is at the first rising edge with iRst_n=1.

## Test plan
- Basic subtractions, each checked for oData, oBorrow, and oDone asserting exactly 8 cycles after start:

  | iB | iData_a | iData_b | oData | oBorrow |
  |----|---------|---------|-------|---------|
  | 0  | 0x01    | 0x01    | 0x00  | 0       |
  | 0  | 0xFF    | 0xFF    | 0x00  | 0       |
  | 0  | 0x89    | 0x8D    | 0xFC  | 1       |

- Borrow chain:
  - iB=0, a=0x00, b=0x01 → oData=0xFF, oBorrow=1
  - iB=1, a=0x00, b=0xFF → oData=0x00, oBorrow=1
  - iB=1, a=0x81, b=0x03 → oData=0x7D, oBorrow=0
- Busy lockout: start a=0x10, b=0x01. Pulse iStart with a=0xAA, b=0x55 at cycle 3.
  - Result is 0x0F, borrow 0.
  - Exactly one oDone pulse; oBusy stays high for 8 cycles.
- Back-to-back: hold iStart=1 with iB=1, a=0x83, b=0x81, then change to a=0x03, b=0x81.
  - Results 0x01/0 then 0x81/1.
  - oDone pulses 9 clocks apart.
- Reset mid-run: assert iRst_n=0 at cycle 4 of a=0x50, b=0x20.
  - All outputs are 0 immediately, state is IDLE, and no oDone appears.
  - A fresh start after release yields 0x30/0.
- Randomized sweep: 1000 random (a, b, iB) triples compared against the reference model (a − b − iB) & 0xFF, with borrow = (a < b + iB). oData must stay stable between oDone pulses.
